// File: rtl/mac32_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac32_seq_pkg : shared types and helpers for the mac32 dot-product sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package mac32_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } seq_state_e;

   localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

   // Exponent all-ones marks both NaN and Inf.
   function automatic logic fp32_is_special(input logic [31:0] v);
      return &v[30:23];
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac32_dot_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac32_dot_seq : valid/ready dot-product sequencer driving combinational MAC32_top
// Optional sticky NaN/Inf flag enabled by defining MAC32_SEQ_EXC_STICKY_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module mac32_dot_seq
   import mac32_seq_pkg::*;
#(
   parameter int PARM_XLEN    = 32,
   parameter int PARM_EXP     = 8,
   parameter int PARM_MANT    = 23,
   parameter int PARM_MAX_LEN = 16,
   localparam int CNTW        = $clog2(PARM_MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [PARM_XLEN-1:0] in_a_i,
   input  logic [PARM_XLEN-1:0] in_b_i,
   input  logic                 in_last_i,
   output logic [PARM_XLEN-1:0] mac_a_o,
   output logic [PARM_XLEN-1:0] mac_b_o,
   output logic [PARM_XLEN-1:0] mac_c_o,
   input  logic [PARM_XLEN-1:0] mac_result_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [PARM_XLEN-1:0] out_data_o,
   output logic [CNTW-1:0]      out_count_o,
   output logic                 out_exc_o
);

   seq_state_e           state;
   seq_state_e           state_nxt;
   logic [PARM_XLEN-1:0] op_a;
   logic [PARM_XLEN-1:0] op_b;
   logic [PARM_XLEN-1:0] acc;
   logic                 op_valid;
   logic [CNTW-1:0]      cnt;
   logic [CNTW-1:0]      cnt_inc;
   logic                 accept;
   logic                 start;
   logic                 capture;
   logic                 hit_max;

   assign in_ready_o = (state == IDLE) || (state == ACCUM);
   assign accept     = in_valid_i & in_ready_o;
   assign start      = accept && (state == IDLE);
   assign cnt_inc    = cnt + CNTW'(1);
   assign hit_max    = (cnt_inc == CNTW'(PARM_MAX_LEN));
   // The MAC result is only meaningful on a cycle that follows a loaded pair.
   assign capture    = ((state == ACCUM) && op_valid) || (state == DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (in_last_i || (PARM_MAX_LEN == 1)) ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && (in_last_i || hit_max)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = OUT;
         end
         OUT: begin
            if (out_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         op_valid <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         op_valid <= accept;
         if (accept) begin
            op_a <= in_a_i;
            op_b <= in_b_i;
         end
         if (start) begin
            acc <= PARM_XLEN'(FP32_POS_ZERO);
            cnt <= CNTW'(1);
         end else begin
            if (capture) begin
               acc <= mac_result_i;
            end
            if (accept) begin
               cnt <= cnt_inc;
            end
         end
      end
   end

   assign mac_a_o     = op_a;
   assign mac_b_o     = op_b;
   assign mac_c_o     = acc;
   assign out_valid_o = (state == OUT);
   assign out_data_o  = acc;
   assign out_count_o = cnt;

`ifdef MAC32_SEQ_EXC_STICKY_EN
   logic exc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc <= 1'b0;
      end else if (start) begin
         exc <= 1'b0;
      end else if (capture && fp32_is_special(32'(mac_result_i))) begin
         exc <= 1'b1;
      end
   end

   assign out_exc_o = exc;
`else
   assign out_exc_o = 1'b0;
`endif

endmodule
`default_nettype wire
